// File: rtl/sdp_wdma_cmd_gen.sv
// SDP write-DMA command generator: walks the output cube line by line
// and issues paired DMA / split commands over valid/ready channels.
module sdp_wdma_cmd_gen #(
    parameter int AW = 59,
    parameter int SW = 13
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          op_load,
    input  logic [31:0]   reg2dp_dst_base_addr_high,
    input  logic [31:0]   reg2dp_dst_base_addr_low,
    input  logic [31:0]   reg2dp_dst_line_stride,
    input  logic [31:0]   reg2dp_dst_surface_stride,
    input  logic [SW-1:0] reg2dp_width,
    input  logic [SW-1:0] reg2dp_height,
    input  logic [SW-1:0] reg2dp_channel,
    output logic          cmd2dat_dma_pvld,
    input  logic          cmd2dat_dma_prdy,
    output logic [AW+SW+1:0] cmd2dat_dma_pd,
    output logic          cmd2dat_spt_pvld,
    input  logic          cmd2dat_spt_prdy,
    output logic [SW+1:0] cmd2dat_spt_pd,
    output logic          cmd_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] line_addr_q, line_addr_d;
    logic [AW-1:0] surf_addr_q, surf_addr_d;
    logic [AW-1:0] lstride_q, lstride_d;
    logic [AW-1:0] sstride_q, sstride_d;
    logic [SW-1:0] width_q, width_d;
    logic [SW-1:0] height_q, height_d;
    logic [7:0]    surf_num_q, surf_num_d;
    logic [SW-1:0] line_cnt_q, line_cnt_d;
    logic [7:0]    surf_cnt_q, surf_cnt_d;
    logic          dma_pvld_q, dma_pvld_d;
    logic          spt_pvld_q, spt_pvld_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] size_q, size_d;
    logic          odd_q, odd_d;
    logic          end_q, end_d;

    logic          last_line, last_surf, last_cmd, both_done;
    logic [AW-1:0] base_addr, surf_addr_nxt;
    logic          unused_bits;

    assign unused_bits = ^{reg2dp_dst_base_addr_high[31:AW-32],
                           reg2dp_channel[4:0]};

    assign base_addr = {reg2dp_dst_base_addr_high[AW-33:0],
                        reg2dp_dst_base_addr_low};
    assign last_line = (line_cnt_q == height_q);
    assign last_surf = (surf_cnt_q == surf_num_q);
    assign last_cmd  = last_line & last_surf;
    // A channel counts as done once its pvld has been dropped or it is being taken now.
    assign both_done = (~dma_pvld_q | cmd2dat_dma_prdy)
                     & (~spt_pvld_q | cmd2dat_spt_prdy);
    assign surf_addr_nxt = surf_addr_q + sstride_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (op_load) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (both_done) state_d = last_cmd ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_addr_d = line_addr_q;
        surf_addr_d = surf_addr_q;
        lstride_d   = lstride_q;
        sstride_d   = sstride_q;
        width_d     = width_q;
        height_d    = height_q;
        surf_num_d  = surf_num_q;
        line_cnt_d  = line_cnt_q;
        surf_cnt_d  = surf_cnt_q;
        dma_pvld_d  = dma_pvld_q;
        spt_pvld_d  = spt_pvld_q;
        addr_d      = addr_q;
        size_d      = size_q;
        odd_d       = odd_q;
        end_d       = end_q;
        unique case (state_q)
            IDLE: begin
                if (op_load) begin
                    line_addr_d = base_addr;
                    surf_addr_d = base_addr;
                    lstride_d   = {{(AW-32){1'b0}}, reg2dp_dst_line_stride};
                    sstride_d   = {{(AW-32){1'b0}}, reg2dp_dst_surface_stride};
                    width_d     = reg2dp_width;
                    height_d    = reg2dp_height;
                    surf_num_d  = reg2dp_channel[12:5];
                    line_cnt_d  = '0;
                    surf_cnt_d  = '0;
                end
            end
            ISSUE: begin
                dma_pvld_d = 1'b1;
                spt_pvld_d = 1'b1;
                addr_d     = line_addr_q;
                size_d     = width_q;
                odd_d      = ~width_q[0];
                end_d      = last_cmd;
            end
            WAIT: begin
                if (cmd2dat_dma_prdy) dma_pvld_d = 1'b0;
                if (cmd2dat_spt_prdy) spt_pvld_d = 1'b0;
                if (both_done && !last_cmd) begin
                    if (last_line) begin
                        surf_addr_d = surf_addr_nxt;
                        line_addr_d = surf_addr_nxt;
                        line_cnt_d  = '0;
                        surf_cnt_d  = surf_cnt_q + 8'd1;
                    end else begin
                        line_addr_d = line_addr_q + lstride_q;
                        line_cnt_d  = line_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            line_addr_q <= '0;
            surf_addr_q <= '0;
            lstride_q   <= '0;
            sstride_q   <= '0;
            width_q     <= '0;
            height_q    <= '0;
            surf_num_q  <= '0;
            line_cnt_q  <= '0;
            surf_cnt_q  <= '0;
            dma_pvld_q  <= 1'b0;
            spt_pvld_q  <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            odd_q       <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            line_addr_q <= line_addr_d;
            surf_addr_q <= surf_addr_d;
            lstride_q   <= lstride_d;
            sstride_q   <= sstride_d;
            width_q     <= width_d;
            height_q    <= height_d;
            surf_num_q  <= surf_num_d;
            line_cnt_q  <= line_cnt_d;
            surf_cnt_q  <= surf_cnt_d;
            dma_pvld_q  <= dma_pvld_d;
            spt_pvld_q  <= spt_pvld_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            odd_q       <= odd_d;
            end_q       <= end_d;
        end
    end

    always_comb begin
        cmd_busy         = (state_q != IDLE);
        cmd2dat_dma_pvld = dma_pvld_q;
        cmd2dat_spt_pvld = spt_pvld_q;
        cmd2dat_dma_pd   = {end_q, odd_q, size_q, addr_q};
        cmd2dat_spt_pd   = {end_q, odd_q, size_q};
    end

endmodule

// File: tb/tb_sdp_wdma_cmd_gen.sv
// Bench for sdp_wdma_cmd_gen: table-driven cube walks checked through a
// command scoreboard, plus latency, skew, ignore and reset sequences.
module tb_sdp_wdma_cmd_gen;

    logic        clk, rst_n, op_load;
    logic [31:0] base_hi, base_lo, lstride, sstride;
    logic [12:0] width, height, channel;
    logic        dma_pvld, dma_prdy, spt_pvld, spt_prdy, cmd_busy;
    logic [73:0] dma_pd;
    logic [14:0] spt_pd;

    sdp_wdma_cmd_gen dut (
        .nvdla_core_clk            (clk),
        .nvdla_core_rstn           (rst_n),
        .op_load                   (op_load),
        .reg2dp_dst_base_addr_high (base_hi),
        .reg2dp_dst_base_addr_low  (base_lo),
        .reg2dp_dst_line_stride    (lstride),
        .reg2dp_dst_surface_stride (sstride),
        .reg2dp_width              (width),
        .reg2dp_height             (height),
        .reg2dp_channel            (channel),
        .cmd2dat_dma_pvld          (dma_pvld),
        .cmd2dat_dma_prdy          (dma_prdy),
        .cmd2dat_dma_pd            (dma_pd),
        .cmd2dat_spt_pvld          (spt_pvld),
        .cmd2dat_spt_prdy          (spt_prdy),
        .cmd2dat_spt_pd            (spt_pd),
        .cmd_busy                  (cmd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [58:0] addr;
        logic [12:0] size;
        logic        odd;
        logic        cend;
    } cmd_t;

    typedef struct {
        logic [58:0] base;
        logic [31:0] ls;
        logic [31:0] ss;
        logic [12:0] w;
        logic [12:0] h;
        logic [12:0] ch;
        bit          rnd;
        int          n;
        logic [58:0] last;
    } vec_t;

    cmd_t dq[$];
    cmd_t sq[$];
    vec_t tab[5];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int seen = 0;
    int last_hs = 0;
    logic [58:0] last_addr;
    logic        dprev_v, dprev_hs, sprev_v, sprev_hs;
    logic [73:0] dprev_pd;
    logic [14:0] sprev_pd;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon();
        cmd_t c;
        if (dma_pvld && dprev_v && !dprev_hs)
            chk("dma_pd_stable", dma_pd, dprev_pd);
        if (spt_pvld && sprev_v && !sprev_hs)
            chk("spt_pd_stable", spt_pd, sprev_pd);
        if (dma_pvld && dma_prdy) begin
            last_hs = cyc_n;
            if (dq.size() == 0) begin
                chk("dma_extra_cmd", 1, 0);
            end else begin
                c = dq.pop_front();
                chk("dma_pd", dma_pd, {c.cend, c.odd, c.size, c.addr});
                seen++;
                last_addr = dma_pd[58:0];
            end
        end
        if (spt_pvld && spt_prdy) begin
            last_hs = cyc_n;
            if (sq.size() == 0) begin
                chk("spt_extra_cmd", 1, 0);
            end else begin
                c = sq.pop_front();
                chk("spt_pd", spt_pd, {c.cend, c.odd, c.size});
            end
        end
        dprev_v  = dma_pvld;
        dprev_hs = dma_pvld & dma_prdy;
        dprev_pd = dma_pd;
        sprev_v  = spt_pvld;
        sprev_hs = spt_pvld & spt_prdy;
        sprev_pd = spt_pd;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Reference walk: address of line l in surface s, computed directly.
    task automatic start(input vec_t v);
        cmd_t c;
        int ns;
        base_hi = {5'b0, v.base[58:32]};
        base_lo = v.base[31:0];
        lstride = v.ls;
        sstride = v.ss;
        width   = v.w;
        height  = v.h;
        channel = v.ch;
        ns = int'(v.ch / 32) + 1;
        for (int s = 0; s < ns; s++) begin
            for (int l = 0; l <= int'(v.h); l++) begin
                c.addr = v.base + 59'(s) * 59'(v.ss) + 59'(l) * 59'(v.ls);
                c.size = v.w;
                c.odd  = (v.w % 2 == 0);
                c.cend = (s == ns - 1) && (l == int'(v.h));
                dq.push_back(c);
                sq.push_back(c);
            end
        end
        seen = 0;
        op_load = 1'b1;
        cyc();
        op_load = 1'b0;
    endtask

    task automatic finish_walk(input string nm, input int n,
                               input logic [58:0] last, input bit rnd);
        bit done = 0;
        for (int k = 0; k < 400; k++) begin
            if (rnd) begin
                dma_prdy = 1'($urandom_range(0, 1));
                spt_prdy = 1'($urandom_range(0, 1));
            end
            cyc();
            if (!cmd_busy) begin
                done = 1;
                break;
            end
        end
        chk({nm, "_timeout"}, done, 1);
        chk({nm, "_count"}, seen, n);
        chk({nm, "_last_addr"}, last_addr, last);
        chk({nm, "_busy_fall"}, cyc_n - last_hs, 1);
        chk({nm, "_queue_left"}, dq.size() + sq.size(), 0);
        dq.delete();
        sq.delete();
    endtask

    initial begin
        tab[0] = '{59'h1000, 32'd8, 32'd0, 13'd7, 13'd1, 13'd31,
                   1'b0, 2, 59'h1008};
        tab[1] = '{59'h2000, 32'd0, 32'h100, 13'd3, 13'd0, 13'd95,
                   1'b0, 3, 59'h2200};
        tab[2] = '{59'h7FF_FFFF_FFFF_FFF8, 32'd16, 32'd0, 13'd1, 13'd1,
                   13'd0, 1'b0, 2, 59'h8};
        tab[3] = '{59'h40, 32'h10, 32'h1000, 13'd4, 13'd2, 13'd63,
                   1'b1, 6, 59'h1060};
        tab[4] = '{59'h5, 32'd3, 32'd7, 13'd0, 13'd0, 13'd0,
                   1'b1, 1, 59'h5};

        rst_n = 1'b0;
        op_load = 1'b0;
        dma_prdy = 1'b0;
        spt_prdy = 1'b0;
        base_hi = '0; base_lo = '0; lstride = '0; sstride = '0;
        width = '0; height = '0; channel = '0;
        dprev_v = 0; dprev_hs = 0; sprev_v = 0; sprev_hs = 0;
        dprev_pd = '0; sprev_pd = '0;
        last_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {dma_pvld, spt_pvld, cmd_busy}, 3'b000);
        chk("rst_dma_pd", dma_pd, 74'h0);
        chk("rst_spt_pd", spt_pd, 15'h0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 5; i++) begin
            dma_prdy = 1'b1;
            spt_prdy = 1'b1;
            start(tab[i]);
            finish_walk($sformatf("vec%0d", i), tab[i].n, tab[i].last,
                        tab[i].rnd);
            cyc();
        end

        // Latency, odd width, skewed ready, op_load ignored mid-run.
        dma_prdy = 1'b0;
        spt_prdy = 1'b1;
        start('{59'h3000, 32'h20, 32'd0, 13'd4, 13'd1, 13'd0,
                1'b0, 2, 59'h3020});
        chk("lat_n1_pvld", {dma_pvld, spt_pvld}, 2'b00);
        cyc();
        chk("lat_n2_pvld", {dma_pvld, spt_pvld}, 2'b11);
        chk("odd_size", dma_pd[72:59], {1'b1, 13'd4});
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("skew_pvld", {dma_pvld, spt_pvld, cmd_busy}, 3'b101);
            chk("skew_dma_addr", dma_pd[58:0], 59'h3000);
            op_load = (k == 2);
            cyc();
        end
        op_load = 1'b0;
        dma_prdy = 1'b1;
        cyc();
        chk("skew_reissue_gap", {dma_pvld, spt_pvld}, 2'b00);
        cyc();
        chk("skew_next_addr", {dma_pvld, dma_pd[58:0]}, {1'b1, 59'h3020});
        finish_walk("skew", 2, 59'h3020, 1'b0);
        cyc();

        // Reset mid-run, then a fresh walk from base.
        dma_prdy = 1'b0;
        spt_prdy = 1'b0;
        start(tab[1]);
        cyc();
        chk("pre_rst_pvld", {dma_pvld, spt_pvld}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {dma_pvld, spt_pvld, cmd_busy}, 3'b000);
        dq.delete();
        sq.delete();
        dprev_v = 0;
        sprev_v = 0;
        #2;
        rst_n = 1'b1;
        dma_prdy = 1'b1;
        spt_prdy = 1'b1;
        cyc();
        cyc();
        chk("post_rst_idle", {dma_pvld, spt_pvld, cmd_busy}, 3'b000);
        start(tab[1]);
        finish_walk("after_rst", 3, 59'h2200, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_wdma_cmd_gen.md
Name: sdp_wdma_cmd_gen

Overview:
- Upstream command generator for the SDP write-DMA data stage.
- On op_load, walks the output cube surface by surface, then line by line within each surface.
- Issues one command per line on two independent valid/ready channels:
  - DMA command: address, size, flags; consumed by the output packer.
  - Split command: size, flags; consumed by the input data FIFO splitter.
- Addresses and sizes are in 32-byte atoms.

Parameters:
- AW, 59, atom address width (64-bit byte address minus 5 LSBs).
- SW, 13, size/counter width.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset; asynchronous assert, active-low
- op_load  in  1  single-cycle start pulse; registers must be stable
- reg2dp_dst_base_addr_high  in  32  base atom address, upper bits (only [26:0] used)
- reg2dp_dst_base_addr_low  in  32  base atom address, low bits
- reg2dp_dst_line_stride  in  32  line stride, atoms
- reg2dp_dst_surface_stride  in  32  surface stride, atoms
- reg2dp_width  in  13  atoms per line minus 1
- reg2dp_height  in  13  lines per surface minus 1
- reg2dp_channel  in  13  channels minus 1; surfaces = channel[12:5]+1
- cmd2dat_dma_pvld  out  1  DMA command valid
- cmd2dat_dma_prdy  in  1  DMA command ready
- cmd2dat_dma_pd  out  74  [58:0] addr, [71:59] size, [72] odd, [73] cube_end
- cmd2dat_spt_pvld  out  1  split command valid
- cmd2dat_spt_prdy  in  1  split command ready
- cmd2dat_spt_pd  out  15  [12:0] size, [13] odd, [14] cube_end
- cmd_busy  out  1  generator active

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters and address registers 0.
- FSM: IDLE -> ISSUE -> WAIT -> ISSUE ... -> IDLE.
  - IDLE: op_load latches base, strides, width, height and surface count. Sets line_addr = surf_addr = base; clears line_cnt and surf_cnt. Moves to ISSUE. op_load outside IDLE is ignored.
  - ISSUE: one cycle; registers the current command and moves to WAIT.
  - WAIT: both pvld outputs held high. A channel's pvld drops the cycle after its own handshake (pvld & prdy) and stays low until the next command. Both handshakes may occur in the same cycle or in different cycles. Once both have occurred, the counters advance:
    - Last line of last surface: go to IDLE.
    - Otherwise: go to ISSUE.
- Latency: op_load in cycle N -> both pvld high in cycle N+2. Back-to-back accepted commands issue one every 2 cycles at best (ISSUE plus at least one WAIT cycle).
- Command fields:
  - size = width.
  - odd = ~width[0] (odd atom count).
  - addr = line_addr.
  - cube_end = 1 only on the last line of the last surface.
  - Both channels carry identical size, odd and cube_end for the same command.
- Address arithmetic: 59-bit adds, wrapping modulo 2^59 with no error flag.
  - Next line in the same surface: line_addr += line_stride.
  - New surface: surf_addr += surface_stride, then line_addr = new surf_addr.
- Counters:
  - line_cnt counts 0..height.
  - surf_cnt counts 0..surfaces-1.
  - height = 0 and/or channel < 32 are legal and produce a single line and/or a single surface.
- pd stability: both pd outputs hold stable while their pvld is high. A channel whose handshake is already done holds pvld low; its pd value is then don't-care.
- cmd_busy = 1 in every state except IDLE.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. No partial command is replayed.

Test Plan:
- Basic walk, always-ready sinks: base=0x1000, width=7, height=1, channel=31, line_stride=8 -> two commands, addr 0x1000 then 0x1008. Both have size=7, odd=0. cube_end=0 then 1.
- Multi-surface: height=0, channel=95, surface_stride=0x100, base=0x2000 -> three commands at 0x2000, 0x2100, 0x2200. cube_end only on the third. cmd_busy falls the cycle after the third handshake.
- Skewed ready:
  - Stimulus: spt_prdy high; dma_prdy low for 5 cycles.
  - Required: spt accepted once and its pvld drops; dma pvld and pd stay stable for the 5 cycles; no next command until the dma handshake, then ISSUE follows.
- Odd width and latency: width=4 -> size=4, odd=1. op_load in cycle N -> pvld high in cycle N+2.
- Wrap and ignore: base near 2^59-8 with line_stride=16 -> second address wraps to 8. op_load pulsed mid-run -> ignored, command count unchanged.
- Reset mid-run: deassert nvdla_core_rstn during WAIT -> pvld outputs 0 immediately. A new op_load after reset starts a fresh walk from base.
